// File: rtl/config_loader.sv
`default_nettype none
// ============================================================================
//  Module      : config_loader
//  Description : Bitstream loader for the tile-array configuration scan chain.
//                Accepts configuration words over a valid/ready handshake and
//                serialises them MSB-first onto the chain, one bit per enabled
//                clock, stopping after exactly CHAIN_LENGTH bits.
//  Optional    : `CONFIG_LOADER_READBACK_EN adds a VERIFY pass that
//                recirculates the chain once and compares a CRC-16 of the
//                shifted stream against a CRC-16 of the returned stream.
//  Ports       : clock, nreset       - clock, async active-low reset
//                start               - single-cycle load request (IDLE/DONE)
//                word_data/valid     - input word and its valid strobe
//                word_ready          - word accepted this cycle (FETCH)
//                chain_data/enable   - first tile config_in / all tiles enable
//                chain_return        - last tile config_out
//                busy, done, error   - status levels
//  Revision    : 1.0 - initial release
// ============================================================================
module config_loader #(
    parameter int CHAIN_LENGTH = 36,
    parameter int WORD_WIDTH   = 8
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  chain_data,
    output logic                  chain_enable,
    input  logic                  chain_return,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int CNT_W  = $clog2(CHAIN_LENGTH + 1);
    localparam int WCNT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

    localparam logic [CNT_W-1:0]  c_LAST_BIT  = CNT_W'(CHAIN_LENGTH - 1);
    localparam logic [WCNT_W-1:0] c_LAST_WBIT = WCNT_W'(WORD_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_SHIFT  = 3'd2,
`ifdef CONFIG_LOADER_READBACK_EN
        S_VERIFY = 3'd4,
`endif
        S_DONE   = 3'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [WORD_WIDTH-1:0] r_buf;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [WCNT_W-1:0]     r_wbit_cnt;
    logic                  w_last_bit;

    assign w_last_bit = (r_bit_cnt == c_LAST_BIT);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        word_ready   = 1'b0;
        chain_enable = 1'b0;
        chain_data   = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_FETCH;
            end
            S_FETCH: begin
                word_ready = 1'b1;
                busy       = 1'b1;
                if (word_valid) w_state_next = S_SHIFT;
            end
            S_SHIFT: begin
                chain_enable = 1'b1;
                chain_data   = r_buf[WORD_WIDTH-1];
                busy         = 1'b1;
                // Chain length wins over word boundary: a partial last word
                // simply stops shifting and its remaining bits are dropped.
                if (w_last_bit) begin
`ifdef CONFIG_LOADER_READBACK_EN
                    w_state_next = S_VERIFY;
`else
                    w_state_next = S_DONE;
`endif
                end else if (r_wbit_cnt == c_LAST_WBIT) begin
                    w_state_next = S_FETCH;
                end
            end
`ifdef CONFIG_LOADER_READBACK_EN
            S_VERIFY: begin
                // Feeding the return straight back rotates the chain by its
                // full length, leaving the loaded contents in place.
                chain_enable = 1'b1;
                chain_data   = chain_return;
                busy         = 1'b1;
                if (w_last_bit) w_state_next = S_DONE;
            end
`endif
            S_DONE: begin
                done = 1'b1;
                if (start) w_state_next = S_FETCH;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Shift buffer and bit counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_buf      <= '0;
            r_bit_cnt  <= '0;
            r_wbit_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) r_bit_cnt <= '0;
                end
                S_FETCH: begin
                    if (word_valid) begin
                        r_buf      <= word_data;
                        r_wbit_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    r_buf      <= r_buf << 1;
                    r_wbit_cnt <= r_wbit_cnt + WCNT_W'(1);
`ifdef CONFIG_LOADER_READBACK_EN
                    // Counter is reused to time the VERIFY pass.
                    if (w_last_bit) r_bit_cnt <= '0;
                    else            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
`else
                    r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
`endif
                end
`ifdef CONFIG_LOADER_READBACK_EN
                S_VERIFY: begin
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                end
`endif
                default: begin
                end
            endcase
        end
    end

`ifdef CONFIG_LOADER_READBACK_EN
    // ------------------------------------------------------------------------
    // Readback CRCs (CRC-16, poly 0x1021, init 0xFFFF, bit-serial)
    // ------------------------------------------------------------------------
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[15] ^ b;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    logic [15:0] r_crc_tx;
    logic [15:0] r_crc_rx;
    logic        r_error;
    logic [15:0] w_crc_rx_next;

    assign w_crc_rx_next = crc16_step(r_crc_rx, chain_return);

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_crc_tx <= '0;
            r_crc_rx <= '0;
            r_error  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_crc_tx <= 16'hFFFF;
                        r_crc_rx <= 16'hFFFF;
                        r_error  <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    r_crc_tx <= crc16_step(r_crc_tx, r_buf[WORD_WIDTH-1]);
                end
                S_VERIFY: begin
                    r_crc_rx <= w_crc_rx_next;
                    // Compare against the CRC including this final bit so
                    // error rises together with done.
                    if (w_last_bit) r_error <= (r_crc_tx != w_crc_rx_next);
                end
                default: begin
                end
            endcase
        end
    end

    assign error = r_error;
`else
    logic w_unused_return;
    assign w_unused_return = chain_return;
    assign error           = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_config_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_config_loader
//  Description : Self-checking bench for config_loader with behavioural
//                scan-chain models (36-bit main instance, 16-bit instance).
//                Expected chain bits and final chain images are queued when
//                stimulus is issued and popped when the DUT produces them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_config_loader;

    localparam int CL = 36;
    localparam int WW = 8;
    localparam int NW = 5;
`ifdef CONFIG_LOADER_READBACK_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif

    logic          clock = 1'b0;
    logic          nreset;
    logic          start;
    logic [WW-1:0] word_data;
    logic          word_valid;
    logic          word_ready;
    logic          chain_data;
    logic          chain_enable;
    logic          chain_return;
    logic          busy;
    logic          done;
    logic          error;

    logic          start2;
    logic [7:0]    wd2;
    logic          wv2;
    logic          rdy2;
    logic          cd2;
    logic          ce2;
    logic          ret2;
    logic          busy2;
    logic          done2;
    logic          err2;

    logic [CL-1:0] chain  = '0;
    logic [15:0]   chain2 = '0;
    logic          stuck20 = 1'b0;

    int            tests = 0;
    int            fails = 0;

    logic [WW-1:0] words  [NW] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'hE0};
    logic [7:0]    words2 [2]  = '{8'h12, 8'h34};

    logic          q_bits  [$];
    logic [63:0]   q_chain [$];

    always #5 clock = ~clock;

    config_loader #(.CHAIN_LENGTH(CL), .WORD_WIDTH(WW)) u_dut (
        .clock       (clock),
        .nreset      (nreset),
        .start       (start),
        .word_data   (word_data),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .chain_data  (chain_data),
        .chain_enable(chain_enable),
        .chain_return(chain_return),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    config_loader #(.CHAIN_LENGTH(16), .WORD_WIDTH(8)) u_dut16 (
        .clock       (clock),
        .nreset      (nreset),
        .start       (start2),
        .word_data   (wd2),
        .word_valid  (wv2),
        .word_ready  (rdy2),
        .chain_data  (cd2),
        .chain_enable(ce2),
        .chain_return(ret2),
        .busy        (busy2),
        .done        (done2),
        .error       (err2)
    );

    // Behavioural chains: first bit shifted ends at the top position.
    assign chain_return = chain[CL-1];
    assign ret2         = chain2[15];

    always @(posedge clock) begin : chain_model
        logic [CL-1:0] nxt;
        nxt = chain_enable ? {chain[CL-2:0], chain_data} : chain;
        if (stuck20) nxt[20] = 1'b0;
        chain <= nxt;
    end

    always @(posedge clock) begin
        if (ce2) chain2 <= {chain2[14:0], cd2};
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full load on the 36-bit instance. abort_at > 0 asserts reset after
    // that many enabled chain cycles and returns without completion checks.
    task automatic run_load(input int gap, input bit pulse, input int abort_at, input logic exp_err);
        int            wi;
        int            gapc;
        int            cyc;
        int            en;
        int            hs;
        int            pushed;
        logic          eb;
        logic [CL-1:0] exp_chain;
        wi = 0; gapc = 0; cyc = 0; en = 0; hs = 0; pushed = 0;
        exp_chain = '0;
        for (int w = 0; w < NW; w++) begin
            for (int b = WW - 1; b >= 0; b--) begin
                if (pushed < CL) begin
                    q_bits.push_back(words[w][b]);
                    exp_chain = {exp_chain[CL-2:0], words[w][b]};
                    pushed++;
                end
            end
        end
        if (abort_at == 0 && exp_err == 1'b0) q_chain.push_back(64'(exp_chain));

        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        check("ready_after_start", 64'(word_ready), 64'd1);

        for (int g = 0; g < 4000; g++) begin
            start      = pulse && (cyc % 3 == 2);
            word_valid = (wi < NW) && (gapc >= gap);
            word_data  = (wi < NW) ? words[wi] : '0;
            @(negedge clock);
            if (word_ready) check("fetch_no_enable", 64'(chain_enable), 64'd0);
            if (chain_enable) begin
                if (en < CL) begin
                    eb = (q_bits.size() > 0) ? q_bits.pop_front() : ~chain_data;
                    check("chain_bit", 64'(chain_data), 64'(eb));
                end
                en++;
            end
            if (word_valid && word_ready) begin
                hs++; wi++; gapc = 0;
            end else begin
                gapc++;
            end
            if (abort_at > 0 && en >= abort_at) begin
                #2 nreset = 1'b0;
                #1 check("async_reset_outputs",
                         64'({word_ready, chain_data, chain_enable, busy, done, error}), 64'd0);
                start = 1'b0; word_valid = 1'b0;
                q_bits.delete();
                @(posedge clock);
                @(negedge clock); nreset = 1'b1;
                return;
            end
            @(posedge clock); #1;
            cyc++;
            if (done) break;
        end
        start = 1'b0; word_valid = 1'b0;
        check("handshakes", 64'(hs), 64'(NW));
        check("enable_cycles", 64'(en), 64'(CL * PASSES));
        check("done", 64'(done), 64'd1);
        check("busy_at_done", 64'(busy), 64'd0);
        check("error_at_done", 64'(error), 64'(exp_err));
        if (exp_err == 1'b0) begin
            check("chain_contents", 64'(chain),
                  (q_chain.size() > 0) ? q_chain.pop_front() : ~64'(chain));
        end
    endtask

    int wi2;
    int en2;

    initial begin
        nreset = 1'b0; start = 1'b0; word_valid = 1'b0; word_data = '0;
        start2 = 1'b0; wv2 = 1'b0; wd2 = '0;
        #1 check("reset_outputs", 64'({word_ready, chain_data, chain_enable, busy, done, error}), 64'd0);
        repeat (3) @(posedge clock);
        @(negedge clock); nreset = 1'b1;

        run_load(0,  1'b0, 0,  1'b0);   // back-to-back words
        run_load(10, 1'b0, 0,  1'b0);   // valid gaps before each word
        run_load(0,  1'b1, 0,  1'b0);   // stray start pulses during load
        run_load(0,  1'b0, 17, 1'b0);   // reset mid-load
        check("idle_after_reset", 64'({busy, done}), 64'd0);
        run_load(0,  1'b0, 0,  1'b0);   // full reload after reset
`ifdef CONFIG_LOADER_READBACK_EN
        stuck20 = 1'b1;
        run_load(0,  1'b0, 0,  1'b1);   // stuck chain bit must flag error
        stuck20 = 1'b0;
`endif

        // 16-bit chain instance
        q_chain.push_back(64'h1234);
        wi2 = 0; en2 = 0;
        @(posedge clock); #1 start2 = 1'b1;
        @(posedge clock); #1 start2 = 1'b0;
        for (int g = 0; g < 500; g++) begin
            wv2 = (wi2 < 2);
            wd2 = (wi2 < 2) ? words2[wi2] : 8'h00;
            @(negedge clock);
            if (ce2) en2++;
            if (wv2 && rdy2) wi2++;
            @(posedge clock); #1;
            if (done2) break;
        end
        wv2 = 1'b0;
        check("c16_enable_cycles", 64'(en2), 64'(16 * PASSES));
        check("c16_done", 64'(done2), 64'd1);
        check("c16_error", 64'(err2), 64'd0);
        check("c16_chain", 64'(chain2), (q_chain.size() > 0) ? q_chain.pop_front() : ~64'(chain2));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
